modadd_arbiter: RTL and testbench

- Two-requester round-robin scheduler that shares the single combinational mod-MODULUS adder/subtractor datapath (4-bit x, y, select s, result z).
- Accepts operations over valid/ready request channels and drives the shared datapath for one cycle per operation.
- Registers the result and returns it to the granted requester over a valid/ready response channel.
- Sits between client blocks and the one datapath instance in the top level.

---
 rtl/modadd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_modadd_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modadd_arbiter.sv
// Round-robin arbiter sharing one mod-MODULUS add/sub datapath between two requesters; 3+ cycles/op, no overlap.
// Latency: accept at N, datapath driven N+1, response N+2; resp held until granted resp_ready. Option: MODADD_RANGE_CHECK_EN.
module modadd_arbiter #(
  parameter int W       = 4,
  parameter int MODULUS = 11,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic             req_s_0,
  input  logic             req_s_1,
  input  logic [W-1:0]     req_x_0,
  input  logic [W-1:0]     req_x_1,
  input  logic [W-1:0]     req_y_0,
  input  logic [W-1:0]     req_y_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [W-1:0]     resp_z,
  output logic             resp_err,
  output logic             dp_s,
  output logic [W-1:0]     dp_x,
  output logic [W-1:0]     dp_y,
  input  logic [W-1:0]     dp_z,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             s_q, s_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     z_q, z_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic             any_vld;
  logic             pick;
  logic             sel_s;
  logic [W-1:0]     sel_x;
  logic [W-1:0]     sel_y;
  logic             oor;
  logic             rsp_rdy;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    any_vld = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      pick = ~last_q;
    end else begin
      pick = req_valid_1;
    end
    sel_s = pick ? req_s_1 : req_s_0;
    sel_x = pick ? req_x_1 : req_x_0;
    sel_y = pick ? req_y_1 : req_y_0;
  end

`ifdef MODADD_RANGE_CHECK_EN
  localparam logic [W:0] MOD_L = (W+1)'(MODULUS);
  assign oor = ({1'b0, sel_x} >= MOD_L) || ({1'b0, sel_y} >= MOD_L);
`else
  assign oor = 1'b0;
`endif

  assign rsp_rdy = gnt_q ? resp_ready_1 : resp_ready_0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    s_d          = s_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    err_d        = err_q;
    ops_d        = ops_q;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    dp_s         = 1'b0;
    dp_x         = '0;
    dp_y         = '0;

    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          req_ready_0 = ~pick;
          req_ready_1 = pick;
          gnt_d       = pick;
          s_d         = sel_s;
          x_d         = sel_x;
          y_d         = sel_y;
          err_d       = oor;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A flagged operation keeps the datapath at zero and returns zero.
        if (err_q) begin
          z_d = '0;
        end else begin
          dp_s = s_q;
          dp_x = x_q;
          dp_y = y_q;
          z_d  = dp_z;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid_0 = ~gnt_q;
        resp_valid_1 = gnt_q;
        if (rsp_rdy) begin
          ops_d   = ops_q + 1'b1;
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      s_q     <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  assign resp_z   = z_q;
  assign resp_err = err_q;
  assign busy     = (state_q != IDLE);
  assign ops_done = ops_q;

endmodule

// File: tb/tb_modadd_arbiter.sv
// Directed bench for modadd_arbiter with a behavioural mod-11 datapath on dp_*.
module tb_modadd_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic       req_s_0, req_s_1;
  logic [3:0] req_x_0, req_x_1, req_y_0, req_y_1;
  logic       resp_valid_0, resp_valid_1;
  logic       resp_ready_0, resp_ready_1;
  logic [3:0] resp_z;
  logic       resp_err;
  logic       dp_s;
  logic [3:0] dp_x, dp_y, dp_z;
  logic       busy;
  logic [7:0] ops_done;

  int checks = 0;
  int errors = 0;

  modadd_arbiter #(.W(4), .MODULUS(11), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_s_0(req_s_0), .req_s_1(req_s_1),
    .req_x_0(req_x_0), .req_x_1(req_x_1),
    .req_y_0(req_y_0), .req_y_1(req_y_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_z(resp_z), .resp_err(resp_err),
    .dp_s(dp_s), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] dp_model(input logic s, input logic [3:0] x, input logic [3:0] y);
    int r;
    if (s) r = ((int'(x) - int'(y)) % 11 + 11) % 11;
    else   r = (int'(x) + int'(y)) % 11;
    return r[3:0];
  endfunction

  assign dp_z = dp_model(dp_s, dp_x, dp_y);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0; req_s_0 = 0; req_s_1 = 0;
    req_x_0 = 0; req_x_1 = 0; req_y_0 = 0; req_y_1 = 0;
    resp_ready_0 = 0; resp_ready_1 = 0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_z, resp_err, dp_s, dp_x, dp_y, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_z, resp_err, dp_s, dp_x, dp_y, busy});
    end
    checks++;
    if (ops_done !== 8'd0) begin errors++; $display("FAIL reset_ops got %0d want 0", ops_done); end
  endtask

  task automatic test_single_add();
    req_valid_0 = 1; req_s_0 = 0; req_x_0 = 7; req_y_0 = 9;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL add_ready got %b%b want 10", req_ready_0, req_ready_1);
    end
    step();
    req_valid_0 = 0; req_x_0 = 0; req_y_0 = 0;
    #1;
    checks++;
    if (dp_x !== 4'd7 || dp_y !== 4'd9 || dp_s !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL add_dp got x=%0d y=%0d s=%b busy=%b want 7 9 0 1", dp_x, dp_y, dp_s, busy);
    end
    checks++;
    if (resp_valid_0 !== 1'b0) begin errors++; $display("FAIL add_early_resp got %b want 0", resp_valid_0); end
    step();
    checks++;
    if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0 || resp_z !== 4'd5 || resp_err !== 1'b0) begin
      errors++; $display("FAIL add_resp got v0=%b v1=%b z=%0d err=%b want 1 0 5 0", resp_valid_0, resp_valid_1, resp_z, resp_err);
    end
    resp_ready_0 = 1;
    step();
    resp_ready_0 = 0;
    #1;
    checks++;
    if (resp_valid_0 !== 1'b0 || ops_done !== 8'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL add_done got v0=%b ops=%0d busy=%b want 0 1 0", resp_valid_0, ops_done, busy);
    end
  endtask

  task automatic test_sub_wrap();
    req_valid_1 = 1; req_s_1 = 1; req_x_1 = 3; req_y_1 = 8;
    #1;
    checks++;
    if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) begin
      errors++; $display("FAIL sub_ready got %b%b want 01", req_ready_0, req_ready_1);
    end
    step();
    req_valid_1 = 0;
    #1;
    checks++;
    if (dp_s !== 1'b1 || dp_x !== 4'd3 || dp_y !== 4'd8) begin
      errors++; $display("FAIL sub_dp got s=%b x=%0d y=%0d want 1 3 8", dp_s, dp_x, dp_y);
    end
    step();
    checks++;
    if (resp_valid_1 !== 1'b1 || resp_valid_0 !== 1'b0 || resp_z !== 4'd6) begin
      errors++; $display("FAIL sub_resp got v1=%b v0=%b z=%0d want 1 0 6", resp_valid_1, resp_valid_0, resp_z);
    end
    resp_ready_1 = 1;
    step();
    resp_ready_1 = 0;
    #1;
    checks++;
    if (ops_done !== 8'd2) begin errors++; $display("FAIL sub_ops got %0d want 2", ops_done); end
  endtask

  task automatic test_round_robin();
    req_valid_0 = 1; req_s_0 = 0; req_x_0 = 2; req_y_0 = 3;
    req_valid_1 = 1; req_s_1 = 1; req_x_1 = 1; req_y_1 = 4;
    resp_ready_0 = 1; resp_ready_1 = 1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      logic [3:0] ez;
      g  = i[0];
      ez = g ? 4'd8 : 4'd5;
      #1;
      checks++;
      if (req_ready_0 !== !g || req_ready_1 !== g) begin
        errors++; $display("FAIL rr_grant%0d got %b%b want %b%b", i, req_ready_0, req_ready_1, !g, g);
      end
      step();
      step();
      checks++;
      if (resp_valid_0 !== !g || resp_valid_1 !== g || resp_z !== ez) begin
        errors++; $display("FAIL rr_resp%0d got v0=%b v1=%b z=%0d want %b %b %0d", i, resp_valid_0, resp_valid_1, resp_z, !g, g, ez);
      end
      step();
    end
    req_valid_0 = 0; req_valid_1 = 0; resp_ready_0 = 0; resp_ready_1 = 0;
    #1;
    checks++;
    if (ops_done !== 8'd6) begin errors++; $display("FAIL rr_ops got %0d want 6", ops_done); end
  endtask

  task automatic test_backpressure();
    req_valid_0 = 1; req_s_0 = 0; req_x_0 = 4; req_y_0 = 4;
    req_valid_1 = 1; req_s_1 = 1; req_x_1 = 10; req_y_1 = 3;
    resp_ready_0 = 0; resp_ready_1 = 1;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL bp_grant got %b%b want 10", req_ready_0, req_ready_1);
    end
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid_0 !== 1'b1 || resp_z !== 4'd8 || req_ready_1 !== 1'b0 || resp_valid_1 !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v0=%b z=%0d rdy1=%b v1=%b want 1 8 0 0", k, resp_valid_0, resp_z, req_ready_1, resp_valid_1);
      end
      step();
    end
    resp_ready_0 = 1;
    step();
    checks++;
    if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0 || ops_done !== 8'd7) begin
      errors++; $display("FAIL bp_release got rdy=%b%b ops=%0d want 01 7", req_ready_0, req_ready_1, ops_done);
    end
    req_valid_0 = 0; resp_ready_0 = 0;
    step();
    req_valid_1 = 0;
    #1;
    checks++;
    if (dp_x !== 4'd10 || dp_y !== 4'd3 || dp_s !== 1'b1) begin
      errors++; $display("FAIL bp_dp got x=%0d y=%0d s=%b want 10 3 1", dp_x, dp_y, dp_s);
    end
    step();
    checks++;
    if (resp_valid_1 !== 1'b1 || resp_z !== 4'd7) begin
      errors++; $display("FAIL bp_resp1 got v1=%b z=%0d want 1 7", resp_valid_1, resp_z);
    end
    step();
    resp_ready_1 = 0;
    #1;
    checks++;
    if (ops_done !== 8'd8 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_ops got ops=%0d busy=%b want 8 0", ops_done, busy);
    end
  endtask

  task automatic test_reset_midop();
    req_valid_0 = 1; req_s_0 = 0; req_x_0 = 1; req_y_0 = 2;
    step();
    req_valid_0 = 0;
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_z, resp_err, dp_s, dp_x, dp_y, busy} !== 21'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %b want 0", {req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_z, resp_err, dp_s, dp_x, dp_y, busy});
    end
    checks++;
    if (ops_done !== 8'd0) begin errors++; $display("FAIL midrst_ops got %0d want 0", ops_done); end
    step();
    checks++;
    if (resp_valid_0 !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_noresp got v0=%b busy=%b want 0 0", resp_valid_0, busy);
    end
    req_valid_1 = 1; req_s_1 = 0; req_x_1 = 5; req_y_1 = 5;
    #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin errors++; $display("FAIL midrst_grant got %b want 1", req_ready_1); end
    step();
    req_valid_1 = 0;
    step();
    checks++;
    if (resp_valid_1 !== 1'b1 || resp_z !== 4'd10) begin
      errors++; $display("FAIL midrst_resp got v1=%b z=%0d want 1 10", resp_valid_1, resp_z);
    end
    resp_ready_1 = 1;
    step();
    resp_ready_1 = 0;
    #1;
    checks++;
    if (ops_done !== 8'd1) begin errors++; $display("FAIL midrst_ops2 got %0d want 1", ops_done); end
  endtask

  task automatic test_range();
    logic [3:0] exp_dx, exp_dy, exp_z;
    logic       exp_err;
`ifdef MODADD_RANGE_CHECK_EN
    exp_dx = 4'd0; exp_dy = 4'd0; exp_z = 4'd0; exp_err = 1'b1;
`else
    exp_dx = 4'd12; exp_dy = 4'd1; exp_z = 4'd2; exp_err = 1'b0;
`endif
    req_valid_0 = 1; req_s_0 = 0; req_x_0 = 12; req_y_0 = 1;
    #1;
    checks++;
    if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL range_grant got %b want 1", req_ready_0); end
    step();
    req_valid_0 = 0;
    #1;
    checks++;
    if (dp_x !== exp_dx || dp_y !== exp_dy || dp_s !== 1'b0) begin
      errors++; $display("FAIL range_dp got x=%0d y=%0d s=%b want %0d %0d 0", dp_x, dp_y, dp_s, exp_dx, exp_dy);
    end
    step();
    checks++;
    if (resp_valid_0 !== 1'b1 || resp_z !== exp_z || resp_err !== exp_err) begin
      errors++; $display("FAIL range_resp got v0=%b z=%0d err=%b want 1 %0d %b", resp_valid_0, resp_z, resp_err, exp_z, exp_err);
    end
    resp_ready_0 = 1;
    step();
    resp_ready_0 = 0;
    #1;
    checks++;
    if (ops_done !== 8'd2) begin errors++; $display("FAIL range_ops got %0d want 2", ops_done); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_add();
    test_sub_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequencing above ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
